// File: rtl/gpr_wb_arbiter.sv
// GPR write-back arbiter: ALU path has priority, LSU returns queue in a FIFO with WAW kill.
// Output registered (ALU 1 cycle, LSU >=2 cycles); LSU backpressured by lsu_ready, ALU by alu_stall.
module gpr_wb_arbiter #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      alu_wr,
  input  logic [AW-1:0]             alu_waddr,
  input  logic [DW-1:0]             alu_wd,
  output logic                      alu_stall,
  input  logic                      lsu_valid,
  output logic                      lsu_ready,
  input  logic [AW-1:0]             lsu_waddr,
  input  logic [DW-1:0]             lsu_wd,
  input  logic [AW-1:0]             raddr0,
  input  logic [AW-1:0]             raddr1,
  input  logic [AW-1:0]             raddr2,
  output logic                      pend0,
  output logic                      pend1,
  output logic                      pend2,
  output logic                      gpr_wr,
  output logic [AW-1:0]             gpr_waddr,
  output logic [DW-1:0]             gpr_wd,
  output logic [$clog2(DEPTH):0]    fifo_cnt
);
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int AGW = $clog2(MAX_WAIT + 2);

  logic [AW-1:0]    fifo_waddr_q [DEPTH];
  logic [DW-1:0]    fifo_wd_q    [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PW-1:0]    rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AGW-1:0]   age_q, age_d;
  logic             stall_q, stall_d;
  logic             gpr_wr_q, gpr_wr_d;
  logic [AW-1:0]    gpr_waddr_q, gpr_waddr_d;
  logic [DW-1:0]    gpr_wd_q, gpr_wd_d;
  logic             empty, full, push, pop, alu_acc;

  always_comb begin
    empty   = (cnt_q == '0);
    full    = (cnt_q == CW'(DEPTH));
    push    = lsu_valid && lsu_ready;
    pop     = !empty && (stall_q || !alu_wr);
    alu_acc = alu_wr && !stall_q;

    vld_d       = vld_q;
    rptr_d      = rptr_q;
    wptr_d      = wptr_q;
    gpr_wr_d    = 1'b0;
    gpr_waddr_d = gpr_waddr_q;
    gpr_wd_d    = gpr_wd_q;

    // A newer ALU write to the same register makes older queued loads obsolete.
    for (int i = 0; i < DEPTH; i++) begin
      if (alu_acc && fifo_waddr_q[i] == alu_waddr) vld_d[i] = 1'b0;
    end

    if (pop) begin
      gpr_wr_d     = vld_q[rptr_q];
      gpr_waddr_d  = fifo_waddr_q[rptr_q];
      gpr_wd_d     = fifo_wd_q[rptr_q];
      vld_d[rptr_q] = 1'b0;
      rptr_d       = rptr_q + PW'(1);
    end else if (alu_acc) begin
      gpr_wr_d    = 1'b1;
      gpr_waddr_d = alu_waddr;
      gpr_wd_d    = alu_wd;
    end

    if (push) begin
      vld_d[wptr_q] = 1'b1;
      wptr_d        = wptr_q + PW'(1);
    end

    cnt_d = cnt_q + CW'(push) - CW'(pop);

    if (empty || pop)                  age_d = '0;
    else if (age_q == AGW'(MAX_WAIT + 1)) age_d = age_q;
    else                               age_d = age_q + AGW'(1);

    stall_d = !empty && !pop && (age_q >= AGW'(MAX_WAIT));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q       <= '0;
      rptr_q      <= '0;
      wptr_q      <= '0;
      cnt_q       <= '0;
      age_q       <= '0;
      stall_q     <= 1'b0;
      gpr_wr_q    <= 1'b0;
      gpr_waddr_q <= '0;
      gpr_wd_q    <= '0;
    end else begin
      vld_q       <= vld_d;
      rptr_q      <= rptr_d;
      wptr_q      <= wptr_d;
      cnt_q       <= cnt_d;
      age_q       <= age_d;
      stall_q     <= stall_d;
      gpr_wr_q    <= gpr_wr_d;
      gpr_waddr_q <= gpr_waddr_d;
      gpr_wd_q    <= gpr_wd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_waddr_q[wptr_q] <= lsu_waddr;
      fifo_wd_q[wptr_q]    <= lsu_wd;
    end
  end

  function automatic logic hit(input logic [AW-1:0] a);
    logic h;
    h = gpr_wr_q && (gpr_waddr_q == a);
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && fifo_waddr_q[i] == a) h = 1'b1;
    end
    return h;
  endfunction

  assign pend0     = !rst && hit(raddr0);
  assign pend1     = !rst && hit(raddr1);
  assign pend2     = !rst && hit(raddr2);
  assign lsu_ready = !rst && !full;
  assign alu_stall = stall_q;
  assign gpr_wr    = gpr_wr_q;
  assign gpr_waddr = gpr_waddr_q;
  assign gpr_wd    = gpr_wd_q;
  assign fifo_cnt  = cnt_q;
endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Directed bench for gpr_wb_arbiter with a shadow register file built from observed GPR writes.
module tb_gpr_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        alu_wr;
  logic [4:0]  alu_waddr;
  logic [31:0] alu_wd;
  logic        alu_stall;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_waddr;
  logic [31:0] lsu_wd;
  logic [4:0]  raddr0, raddr1, raddr2;
  logic        pend0, pend1, pend2;
  logic        gpr_wr;
  logic [4:0]  gpr_waddr;
  logic [31:0] gpr_wd;
  logic [2:0]  fifo_cnt;

  int errors = 0;
  int checks = 0;
  logic [31:0] r_model [32];
  bit          seen    [32];

  gpr_wb_arbiter #(.DW(32), .AW(5), .DEPTH(4), .MAX_WAIT(8)) dut (
    .clk(clk), .rst(rst),
    .alu_wr(alu_wr), .alu_waddr(alu_waddr), .alu_wd(alu_wd), .alu_stall(alu_stall),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_waddr(lsu_waddr), .lsu_wd(lsu_wd),
    .raddr0(raddr0), .raddr1(raddr1), .raddr2(raddr2),
    .pend0(pend0), .pend1(pend1), .pend2(pend2),
    .gpr_wr(gpr_wr), .gpr_waddr(gpr_waddr), .gpr_wd(gpr_wd), .fifo_cnt(fifo_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (gpr_wr) begin
      r_model[gpr_waddr] = gpr_wd;
      seen[gpr_waddr]    = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      r_model[i] = '0;
      seen[i]    = 1'b0;
    end
    rst = 1'b1; alu_wr = 1'b0; alu_waddr = '0; alu_wd = '0;
    lsu_valid = 1'b0; lsu_waddr = '0; lsu_wd = '0;
    raddr0 = '0; raddr1 = '0; raddr2 = '0;
    tick(); tick();
    chk("rst_lsu_ready", 64'(lsu_ready), 64'd0);
    chk("rst_pend0", 64'(pend0), 64'd0);
    chk("rst_gpr_wr", 64'(gpr_wr), 64'd0);
    chk("rst_gpr_waddr", 64'(gpr_waddr), 64'd0);
    chk("rst_gpr_wd", 64'(gpr_wd), 64'd0);
    chk("rst_alu_stall", 64'(alu_stall), 64'd0);
    chk("rst_fifo_cnt", 64'(fifo_cnt), 64'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_lsu_ready", 64'(lsu_ready), 64'd1);

    // ALU only
    alu_wr = 1'b1; alu_waddr = 5'd3; alu_wd = 32'h1234; raddr0 = 5'd3;
    #1;
    chk("alu_pend0_same_cycle", 64'(pend0), 64'd0);
    tick();
    alu_wr = 1'b0;
    chk("alu_gpr_wr", 64'(gpr_wr), 64'd1);
    chk("alu_gpr_waddr", 64'(gpr_waddr), 64'd3);
    chk("alu_gpr_wd", 64'(gpr_wd), 64'h1234);
    tick();
    chk("idle_gpr_wr", 64'(gpr_wr), 64'd0);
    chk("idle_hold_waddr", 64'(gpr_waddr), 64'd3);
    chk("idle_hold_wd", 64'(gpr_wd), 64'h1234);

    // LSU only
    lsu_valid = 1'b1; lsu_waddr = 5'd7; lsu_wd = 32'hCAFE; raddr1 = 5'd7;
    #1;
    chk("lsu_pend1_push_cycle", 64'(pend1), 64'd0);
    tick();
    lsu_valid = 1'b0;
    #1;
    chk("lsu_cnt_n1", 64'(fifo_cnt), 64'd1);
    chk("lsu_pend1_n1", 64'(pend1), 64'd1);
    chk("lsu_gpr_wr_n1", 64'(gpr_wr), 64'd0);
    tick();
    chk("lsu_gpr_wr_n2", 64'(gpr_wr), 64'd1);
    chk("lsu_gpr_waddr_n2", 64'(gpr_waddr), 64'd7);
    chk("lsu_gpr_wd_n2", 64'(gpr_wd), 64'hCAFE);
    chk("lsu_pend1_n2", 64'(pend1), 64'd1);
    chk("lsu_cnt_n2", 64'(fifo_cnt), 64'd0);
    tick();
    chk("lsu_pend1_n3", 64'(pend1), 64'd0);

    // Full FIFO while ALU holds the write port
    alu_wr = 1'b1; alu_waddr = 5'd1; alu_wd = 32'h11;
    for (int i = 0; i < 4; i++) begin
      lsu_valid = 1'b1; lsu_waddr = 5'(10 + i); lsu_wd = 32'h100 + 32'(i);
      tick();
    end
    chk("full_cnt", 64'(fifo_cnt), 64'd4);
    chk("full_lsu_ready", 64'(lsu_ready), 64'd0);
    lsu_waddr = 5'd20; lsu_wd = 32'hDEAD;
    tick();
    chk("full_cnt_after_5th", 64'(fifo_cnt), 64'd4);
    alu_wr = 1'b0; lsu_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("drain_gpr_wr", 64'(gpr_wr), 64'd1);
      chk("drain_waddr", 64'(gpr_waddr), 64'(10 + i));
      chk("drain_wd", 64'(gpr_wd), 64'h100 + 64'(i));
    end
    chk("drain_cnt", 64'(fifo_cnt), 64'd0);
    tick();
    chk("drain_no_5th", 64'(gpr_wr), 64'd0);
    chk("drain_r20_unwritten", 64'(seen[20]), 64'd0);

    // WAW kill
    lsu_valid = 1'b1; lsu_waddr = 5'd5; lsu_wd = 32'hAA;
    alu_wr = 1'b1; alu_waddr = 5'd2; alu_wd = 32'h22;
    tick();
    lsu_valid = 1'b0; alu_waddr = 5'd5; alu_wd = 32'hBB; raddr2 = 5'd5;
    #1;
    chk("waw_pend2_queued", 64'(pend2), 64'd1);
    tick();
    alu_wr = 1'b0;
    chk("waw_alu_wr", 64'(gpr_wr), 64'd1);
    chk("waw_alu_waddr", 64'(gpr_waddr), 64'd5);
    chk("waw_alu_wd", 64'(gpr_wd), 64'hBB);
    tick();
    chk("waw_killed_gpr_wr", 64'(gpr_wr), 64'd0);
    chk("waw_cnt", 64'(fifo_cnt), 64'd0);
    chk("waw_pend2_clear", 64'(pend2), 64'd0);
    chk("waw_r5_final", 64'(r_model[5]), 64'hBB);

    // Starvation guard
    lsu_valid = 1'b1; lsu_waddr = 5'd9; lsu_wd = 32'h99;
    alu_wr = 1'b1; alu_waddr = 5'd4; alu_wd = 32'h44;
    tick();
    lsu_valid = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      chk("starve_no_stall_yet", 64'(alu_stall), 64'd0);
      tick();
    end
    chk("starve_stall", 64'(alu_stall), 64'd1);
    tick();
    chk("starve_pop_gpr_wr", 64'(gpr_wr), 64'd1);
    chk("starve_pop_waddr", 64'(gpr_waddr), 64'd9);
    chk("starve_pop_wd", 64'(gpr_wd), 64'h99);
    chk("starve_stall_clear", 64'(alu_stall), 64'd0);
    tick();
    chk("starve_alu_resumes", 64'(gpr_waddr), 64'd4);
    alu_wr = 1'b0;
    tick();

    // Reset discards queued entries
    alu_wr = 1'b1; alu_waddr = 5'd1; alu_wd = 32'h11;
    for (int i = 0; i < 3; i++) begin
      lsu_valid = 1'b1; lsu_waddr = 5'(24 + i); lsu_wd = 32'h300 + 32'(i);
      tick();
    end
    chk("rstq_cnt3", 64'(fifo_cnt), 64'd3);
    rst = 1'b1; alu_wr = 1'b0; lsu_valid = 1'b0; raddr0 = 5'd24;
    tick();
    chk("rstq_cnt0", 64'(fifo_cnt), 64'd0);
    chk("rstq_gpr_wr", 64'(gpr_wr), 64'd0);
    chk("rstq_lsu_ready", 64'(lsu_ready), 64'd0);
    chk("rstq_pend0", 64'(pend0), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("rstq_r24", 64'(seen[24]), 64'd0);
    chk("rstq_r25", 64'(seen[25]), 64'd0);
    chk("rstq_r26", 64'(seen[26]), 64'd0);
    chk("rstq_lsu_ready_after", 64'(lsu_ready), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
